// File: rtl/dmem_sequencer_if.sv
// Data-memory request/grant/response bus.
// The sequencer drives the master side; the memory drives the slave side.
interface dmem_if #(
  parameter int W = 32
);
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic [3:0]   be;
  logic         gnt;
  logic         rvalid;
  logic [W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_sequencer.sv
// Memory-stage load/store sequencer: one access outstanding,
// stalls the pipeline until the data-memory access completes.
module dmem_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_load_op_i,
  input  logic              is_store_op_i,
  input  logic              is_byte_op_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  dmem_if.master            mem,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic              mem_op;
  logic              misalign;
  logic              timeout;
  logic              ld_done;
  logic              set_err;
  logic              st_q;
  logic              byte_q;
  logic [1:0]        off_q;
  logic [4:0]        rd_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] ld_data;

  assign mem_op   = valid_i & (is_load_op_i | is_store_op_i);
  assign misalign = ~is_byte_op_i & (addr_i[1:0] != 2'b00);
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES));

  assign ld_data = byte_q
    ? {{(DATA_W-8){1'b0}}, mem.rdata[{off_q, 3'b000} +: 8]}
    : mem.rdata;

  // Request is withdrawn in the timeout cycle so a late grant cannot land.
  assign mem.req   = (state == REQ) & ~timeout;
  assign mem.we    = st_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.be    = be_q;

  assign stall_o = (state == REQ) | (state == WAIT)
                 | ((state == IDLE) & mem_op);

  always_comb begin
    state_n = state;
    ld_done = 1'b0;
    set_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          if (misalign) begin
            set_err = 1'b1;
            state_n = DONE;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          set_err = 1'b1;
          state_n = DONE;
        end else if (mem.gnt) begin
          if (st_q) begin
            state_n = DONE;
          end else if (mem.rvalid) begin
            ld_done = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (timeout) begin
          set_err = 1'b1;
          state_n = DONE;
        end else if (mem.rvalid) begin
          ld_done = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      err_o      <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      st_q       <= 1'b0;
      byte_q     <= 1'b0;
      off_q      <= '0;
      rd_q       <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state      <= state_n;
      err_o      <= err_o | set_err;
      wb_valid_o <= ld_done;
      wb_rd_o    <= ld_done ? rd_q : 5'd0;
      wb_data_o  <= ld_done ? ld_data : '0;
      if ((state == IDLE) && mem_op) begin
        st_q    <= is_store_op_i;
        byte_q  <= is_byte_op_i;
        off_q   <= addr_i[1:0];
        rd_q    <= rd_i;
        cnt     <= '0;
        addr_q  <= {addr_i[DATA_W-1:2], 2'b00};
        wdata_q <= is_byte_op_i ? {4{store_data_i[7:0]}}
                                : store_data_i;
        be_q    <= (is_store_op_i & is_byte_op_i)
                   ? (4'b0001 << addr_i[1:0]) : 4'hF;
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Randomized and directed bench for dmem_sequencer with a
// transaction-level reference model and a bus responder.
module tb_dmem_sequencer;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic        is_load_op_i = 1'b0;
  logic        is_store_op_i = 1'b0;
  logic        is_byte_op_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  dmem_if mem_bus ();

  dmem_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .is_load_op_i (is_load_op_i),
    .is_store_op_i(is_store_op_i),
    .is_byte_op_i (is_byte_op_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .rd_i         (rd_i),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .mem          (mem_bus.master),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done;
    int          reqs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wbv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    bit          stable;
    bit          stall_ok;
  } obs_t;

  typedef struct {
    int          done;
    int          reqs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wbv;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  // Transaction-level expectation; cycles counted from the accept cycle.
  function automatic exp_t model(
    input bit ld, st, byt, input logic [31:0] a, d,
    input logic [4:0] r, input int gdly, rdly, input logic [31:0] rdat);
    exp_t e;
    bit is_st;
    is_st = st;
    e = '{default: 0};
    if (!byt && a[1:0] != 2'b00) begin
      e.done = 1;
      return e;
    end
    if (gdly >= TO) begin
      e.done = TO + 2;
      e.reqs = TO;
    end else begin
      e.done = 2 + gdly + (is_st ? 0 : rdly);
      e.reqs = gdly + 1;
      e.wbv  = is_st ? 0 : 1;
    end
    e.we    = is_st;
    e.addr  = a & 32'hFFFF_FFFC;
    e.be    = (is_st && byt) ? (4'b0001 << a[1:0]) : 4'hF;
    e.wdata = byt ? {4{d[7:0]}} : d;
    e.rd    = r;
    e.data  = byt ? ((rdat >> (8 * a[1:0])) & 32'hFF) : rdat;
    return e;
  endfunction

  // Presents one op and plays the memory side until stall_o drops.
  task automatic run_op(
    input bit ld, st, byt, input logic [31:0] a, d,
    input logic [4:0] r, input int gdly, rdly, poke,
    input logic [31:0] rdat, output obs_t o);
    int  wcnt;
    bit  granted;
    bit  g, rv;
    o = '{default: 0};
    o.done = -1;
    o.stable = 1;
    o.stall_ok = 1;
    wcnt = 0;
    granted = 0;
    @(negedge clk);
    valid_i = 1'b1;
    is_load_op_i = ld;
    is_store_op_i = st;
    is_byte_op_i = byt;
    addr_i = a;
    store_data_i = d;
    rd_i = r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc > 0 && !stall_o) begin
        o.done = cyc;
        o.err = err_o;
        if (wb_valid_o) begin
          o.wbv++;
          o.rd = wb_rd_o;
          o.data = wb_data_o;
        end
        break;
      end
      if (!stall_o) o.stall_ok = 0;
      if (wb_valid_o) o.wbv++;
      g = 0;
      rv = 0;
      if (mem_bus.req) begin
        if (o.reqs == 0) begin
          o.we = mem_bus.we;
          o.addr = mem_bus.addr;
          o.wdata = mem_bus.wdata;
          o.be = mem_bus.be;
        end else if ({o.we, o.addr, o.wdata, o.be} !==
                     {mem_bus.we, mem_bus.addr, mem_bus.wdata, mem_bus.be}) begin
          o.stable = 0;
        end
        o.reqs++;
        if (o.reqs == gdly + 1) begin
          g = 1;
          granted = 1;
          if (!st && rdly == 0) rv = 1;
        end
      end else if (granted && !st) begin
        wcnt++;
        if (wcnt == rdly) rv = 1;
      end
      if (cyc == poke) begin
        g = 1;
        rv = 1;
      end
      mem_bus.gnt = g;
      mem_bus.rvalid = rv;
      mem_bus.rdata = rv ? rdat : $urandom();
    end
    valid_i = 1'b0;
    is_load_op_i = 1'b0;
    is_store_op_i = 1'b0;
    is_byte_op_i = 1'b0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall_o, wb_valid_o, wb_rd_o, wb_data_o, mem_bus.req, mem_bus.we,
         mem_bus.addr, mem_bus.wdata, mem_bus.be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b wbv=%b req=%b we=%b addr=%h be=%h want all 0",
               stall_o, wb_valid_o, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.be);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err_o);
    end
    reset = 1'b0;
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({stall_o, mem_bus.req} !== 2'b00) begin
        errors++;
        $display("FAIL nonmem: stall=%b req=%b want 0 0", stall_o, mem_bus.req);
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic test_sw();
    obs_t o;
    run_op(0, 1, 0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, -1, 32'h0, o);
    checks++;
    if (o.done !== 2 || !o.stall_ok) begin
      errors++;
      $display("FAIL sw_timing: done=%0d stall_ok=%0d want 2 1", o.done, o.stall_ok);
    end
    checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_bus: we=%b addr=%h be=%h wdata=%h want 1 100 f deadbeef",
               o.we, o.addr, o.be, o.wdata);
    end
    checks++;
    if (o.wbv !== 0 || o.err !== 1'b0) begin
      errors++;
      $display("FAIL sw_wb: wbv=%0d err=%b want 0 0", o.wbv, o.err);
    end
  endtask

  task automatic test_sb();
    obs_t o;
    run_op(0, 1, 1, 32'h203, 32'h0000005A, 5'd0, 1, 0, -1, 32'h0, o);
    checks++;
    if ({o.we, o.addr, o.be, o.wdata} !== {1'b1, 32'h200, 4'b1000, 32'h5A5A5A5A}) begin
      errors++;
      $display("FAIL sb_bus: we=%b addr=%h be=%h wdata=%h want 1 200 8 5a5a5a5a",
               o.we, o.addr, o.be, o.wdata);
    end
    checks++;
    if (o.done !== 3 || o.reqs !== 2 || !o.stable) begin
      errors++;
      $display("FAIL sb_timing: done=%0d reqs=%0d stable=%0d want 3 2 1",
               o.done, o.reqs, o.stable);
    end
  endtask

  task automatic test_lbu();
    obs_t o;
    run_op(1, 0, 1, 32'h102, 32'h0, 5'd7, 0, 2, -1, 32'h11223344, o);
    checks++;
    if (o.done !== 4 || !o.stall_ok) begin
      errors++;
      $display("FAIL lbu_timing: done=%0d stall_ok=%0d want 4 1", o.done, o.stall_ok);
    end
    checks++;
    if (o.wbv !== 1 || o.rd !== 5'd7 || o.data !== 32'h22) begin
      errors++;
      $display("FAIL lbu_wb: wbv=%0d rd=%0d data=%h want 1 7 00000022",
               o.wbv, o.rd, o.data);
    end
    checks++;
    if (o.be !== 4'hF || o.we !== 1'b0 || o.addr !== 32'h100) begin
      errors++;
      $display("FAIL lbu_bus: be=%h we=%b addr=%h want f 0 100", o.be, o.we, o.addr);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic err_exp;
    err_exp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int k, gdly, rdly;
      bit ld, st, byt;
      logic [31:0] a, d, rdat;
      logic [4:0] r;
      k = $urandom_range(0, 4);
      ld = (k <= 1) || (k == 4);
      st = (k == 2) || (k == 3) || (k == 4);
      byt = $urandom_range(0, 1);
      a = $urandom();
      if (!byt && $urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      d = $urandom();
      r = 5'($urandom_range(0, 31));
      gdly = $urandom_range(0, 3);
      rdly = $urandom_range(0, 3);
      rdat = $urandom();
      e = model(ld, st, byt, a, d, r, gdly, rdly, rdat);
      if (!byt && a[1:0] != 2'b00) err_exp = 1'b1;
      run_op(ld, st, byt, a, d, r, gdly, rdly, -1, rdat, o);
      checks++;
      if (o.done !== e.done || !o.stall_ok || o.reqs !== e.reqs) begin
        errors++;
        $display("FAIL rnd%0d_timing: done=%0d reqs=%0d stall_ok=%0d want %0d %0d 1",
                 i, o.done, o.reqs, o.stall_ok, e.done, e.reqs);
      end
      checks++;
      if (o.wbv !== e.wbv || (e.wbv == 1 && {o.rd, o.data} !== {e.rd, e.data})) begin
        errors++;
        $display("FAIL rnd%0d_wb: wbv=%0d rd=%0d data=%h want %0d %0d %h",
                 i, o.wbv, o.rd, o.data, e.wbv, e.rd, e.data);
      end
      if (e.reqs > 0) begin
        checks++;
        if ({o.we, o.addr, o.be} !== {e.we, e.addr, e.be} || !o.stable ||
            (e.we && o.wdata !== e.wdata)) begin
          errors++;
          $display("FAIL rnd%0d_bus: we=%b addr=%h be=%h wdata=%h want %b %h %h %h",
                   i, o.we, o.addr, o.be, o.wdata, e.we, e.addr, e.be, e.wdata);
        end
      end
      checks++;
      if (o.err !== err_exp) begin
        errors++;
        $display("FAIL rnd%0d_err: got %b want %b", i, o.err, err_exp);
      end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1, 0, 0, 32'h106, 32'h0, 5'd4, 0, 0, -1, 32'h0, o);
    checks++;
    if (o.done !== 1 || o.reqs !== 0 || o.wbv !== 0 || o.err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned: done=%0d reqs=%0d wbv=%0d err=%b want 1 0 0 1",
               o.done, o.reqs, o.wbv, o.err);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(0, 1, 0, 32'h300, 32'hCAFEF00D, 5'd0, 10000, 0, TO + 1, 32'h0, o);
    checks++;
    if (o.reqs !== TO || !o.stable || o.done !== TO + 2) begin
      errors++;
      $display("FAIL timeout_req: reqs=%0d stable=%0d done=%0d want %0d 1 %0d",
               o.reqs, o.stable, o.done, TO, TO + 2);
    end
    checks++;
    if (o.err !== 1'b1 || o.wbv !== 0) begin
      errors++;
      $display("FAIL timeout_err: err=%b wbv=%0d want 1 0", o.err, o.wbv);
    end
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({wb_valid_o, stall_o, mem_bus.req} !== 3'b000) begin
        errors++;
        $display("FAIL late_rvalid: wbv=%b stall=%b req=%b want 0 0 0",
                 wb_valid_o, stall_o, mem_bus.req);
      end
    end
    mem_bus.rvalid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    @(negedge clk);
    valid_i = 1'b1;
    is_load_op_i = 1'b1;
    addr_i = 32'h40;
    rd_i = 5'd3;
    @(negedge clk);
    #1;
    checks++;
    if (mem_bus.req !== 1'b1) begin
      errors++;
      $display("FAIL rstw_req: got %b want 1", mem_bus.req);
    end
    mem_bus.gnt = 1'b1;
    @(negedge clk);
    #1;
    mem_bus.gnt = 1'b0;
    checks++;
    if ({mem_bus.req, stall_o} !== 2'b01) begin
      errors++;
      $display("FAIL rstw_wait: req=%b stall=%b want 0 1", mem_bus.req, stall_o);
    end
    reset = 1'b1;
    valid_i = 1'b0;
    is_load_op_i = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({stall_o, wb_valid_o, wb_rd_o, wb_data_o, mem_bus.req, mem_bus.we,
         mem_bus.addr, mem_bus.wdata, mem_bus.be, err_o} !== '0) begin
      errors++;
      $display("FAIL rstw_outputs: stall=%b wbv=%b req=%b addr=%h be=%h err=%b want all 0",
               stall_o, wb_valid_o, mem_bus.req, mem_bus.addr, mem_bus.be, err_o);
    end
    run_op(1, 0, 0, 32'h80, 32'h0, 5'd9, 1, 1, -1, 32'hA5A5_0F0F, o);
    checks++;
    if (o.done !== 4 || o.wbv !== 1 || o.rd !== 5'd9 ||
        o.data !== 32'hA5A5_0F0F || o.err !== 1'b0) begin
      errors++;
      $display("FAIL rstw_lw: done=%0d wbv=%0d rd=%0d data=%h err=%b want 4 1 9 a5a50f0f 0",
               o.done, o.wbv, o.rd, o.data, o.err);
    end
  endtask

  initial begin
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata = '0;
    test_reset();
    test_nonmem();
    test_sw();
    test_sb();
    test_lbu();
    test_random();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
